// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: word type, RAM handshake states and
// the arbiter's own FSM states.
package cpu_types_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    DACC,
    IACC,
    DRSP,
    IRSP,
    ERR
  } arb_state_t;

  // True while the arbiter owns the RAM port and is waiting for completion.
  function automatic logic is_access(arb_state_t s);
    return (s == DACC) || (s == IACC);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request-side and RAM-side signals of the arbiter. master is the arbiter's
// view; slave is the view of the request unit and RAM around it.
interface mem_arbiter_if #(
  parameter int WORD_W = 32
);
  import cpu_types_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              merr;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_timer.sv
// Access watchdog: counts cycles spent waiting on the RAM and flags expiry
// once TIMEOUT cycles have elapsed since the last clear.
module arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at LAST so the flag stays up until the owner clears it.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises data and instruction accesses onto one shared RAM port, data
// first, returning one-cycle hit pulses with the loaded word.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int WORD_W  = WORD_WIDTH
) (
  input  logic          CLK,
  input  logic          Rst,
  mem_arbiter_if.master bus
);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [WORD_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_store;
  logic              lat_write;
  logic [WORD_W-1:0] iload_q;
  logic [WORD_W-1:0] dload_q;
  logic              in_access;
  logic              expired;
  logic              ram_ready;
  logic              ram_fail;
  logic              data_req;

  assign in_access = is_access(state);
  assign data_req  = bus.dWEN || bus.dREN;
  assign ram_ready = (bus.ramstate == ACCESS);
  assign ram_fail  = (bus.ramstate == ERROR) || expired;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .Rst     (Rst),
    .clear   (!in_access),
    .enable  (in_access),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The response states always return to IDLE, giving the requester one
  // cycle to drop its enable before it is sampled again.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (data_req) begin
          next_state = DACC;
        end else if (bus.iREN) begin
          next_state = IACC;
        end
      end
      DACC: begin
        if (ram_ready) begin
          next_state = DRSP;
        end else if (ram_fail) begin
          next_state = ERR;
        end
      end
      IACC: begin
        if (ram_ready) begin
          next_state = IRSP;
        end else if (ram_fail) begin
          next_state = ERR;
        end
      end
      DRSP:    next_state = IDLE;
      IRSP:    next_state = IDLE;
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured once so the access is immune to the
  // requester changing or dropping its inputs mid-flight.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      lat_addr  <= '0;
      lat_store <= '0;
      lat_write <= 1'b0;
    end else if (state == IDLE) begin
      if (data_req) begin
        lat_addr  <= bus.daddr;
        lat_store <= bus.dstore;
        lat_write <= bus.dWEN;
      end else if (bus.iREN) begin
        lat_addr  <= bus.iaddr;
        lat_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      iload_q <= '0;
      dload_q <= '0;
    end else if (ram_ready) begin
      if (state == IACC) begin
        iload_q <= bus.ramload;
      end else if (state == DACC && !lat_write) begin
        dload_q <= bus.ramload;
      end
    end
  end

  assign bus.ramREN   = (state == IACC) || (state == DACC && !lat_write);
  assign bus.ramWEN   = (state == DACC) && lat_write;
  assign bus.ramaddr  = lat_addr;
  assign bus.ramstore = lat_store;
  assign bus.ihit     = (state == IRSP);
  assign bus.dhit     = (state == DRSP);
  assign bus.merr     = (state == ERR);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;

  assert property (@(posedge CLK) disable iff (Rst) !(bus.ramREN && bus.ramWEN));
  assert property (@(posedge CLK) disable iff (Rst) !(bus.ihit && bus.dhit));

endmodule
